// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard controller for the 5-stage MIPS core.
// Shadows EX/MEM/WB destination bookkeeping and drives EX operand-select codes and the ID stall.
module fwd_hazard_unit #(
  parameter int AW   = 5,
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [AW-1:0]   id_rs,
  input  logic [AW-1:0]   id_rt,
  input  logic            id_use_rs,
  input  logic            id_use_rt,
  input  logic [AW-1:0]   id_wreg,
  input  logic            id_we,
  input  logic            id_load,
  input  logic            ext_stall,
  input  logic            flush,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b,
  output logic            stall_id,
  output logic [CNTW-1:0] bubble_cnt
);

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] wreg;
    logic          we;
    logic          load;
  } dst_t;

  typedef struct packed {
    dst_t          dst;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic          use_rs;
    logic          use_rt;
  } ex_t;

  localparam logic [AW-1:0] REG_ZERO  = {AW{1'b0}};
  localparam dst_t          DST_BUB   = '{valid: 1'b0, wreg: {AW{1'b0}}, we: 1'b0, load: 1'b0};
  localparam ex_t           EX_BUB    = '{dst: DST_BUB, rs: {AW{1'b0}}, rt: {AW{1'b0}},
                                          use_rs: 1'b0, use_rt: 1'b0};

  ex_t             ex_q,  ex_d;
  dst_t            mem_q, mem_d;
  dst_t            wb_q,  wb_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  ex_t             id_ent_s;
  logic            lu_s;

  // Youngest-producer-wins select; a load sitting in MEM has no result yet.
  function automatic logic [1:0] fwd_sel(
    input logic          ex_valid,
    input logic          src_used,
    input logic [AW-1:0] src,
    input dst_t          mem,
    input dst_t          wb
  );
    logic [1:0] sel;
    if (!ex_valid || !src_used || src == REG_ZERO) begin
      sel = 2'd0;
    end else if (mem.valid && mem.we && !mem.load && mem.wreg == src) begin
      sel = 2'd1;
    end else if (wb.valid && wb.we && wb.wreg == src) begin
      sel = 2'd2;
    end else begin
      sel = 2'd0;
    end
    return sel;
  endfunction

  // Pack the ID-stage instruction into an EX entry and detect load-use.
  always_comb begin
    id_ent_s            = EX_BUB;
    id_ent_s.dst.valid  = id_valid;
    id_ent_s.dst.wreg   = id_wreg;
    id_ent_s.dst.we     = id_we;
    id_ent_s.dst.load   = id_load;
    id_ent_s.rs         = id_rs;
    id_ent_s.rt         = id_rt;
    id_ent_s.use_rs     = id_use_rs;
    id_ent_s.use_rt     = id_use_rt;
    lu_s = id_valid && ex_q.dst.valid && ex_q.dst.load && ex_q.dst.we &&
           (ex_q.dst.wreg != REG_ZERO) &&
           ((id_use_rs && id_rs == ex_q.dst.wreg) || (id_use_rt && id_rt == ex_q.dst.wreg));
  end

  // Pipeline advance: flush beats freeze, freeze beats normal flow.
  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    cnt_d = cnt_q;
    if (flush) begin
      wb_d  = mem_q;
      mem_d = DST_BUB;
      ex_d  = EX_BUB;
    end else if (ext_stall) begin
      ex_d  = ex_q;
      mem_d = mem_q;
      wb_d  = wb_q;
    end else begin
      wb_d  = mem_q;
      mem_d = ex_q.dst;
      if (lu_s || !id_valid) begin
        ex_d = EX_BUB;
      end else begin
        ex_d = id_ent_s;
      end
      if (lu_s) begin
        cnt_d = cnt_q + CNTW'(1'b1);
      end else begin
        cnt_d = cnt_q;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= EX_BUB;
      mem_q <= DST_BUB;
      wb_q  <= DST_BUB;
      cnt_q <= {CNTW{1'b0}};
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

  // Operand selects depend only on registered state, so they hold steady during a freeze.
  always_comb begin
    fwd_a = fwd_sel(ex_q.dst.valid, ex_q.use_rs, ex_q.rs, mem_q, wb_q);
    fwd_b = fwd_sel(ex_q.dst.valid, ex_q.use_rt, ex_q.rt, mem_q, wb_q);
  end

  assign stall_id   = lu_s & ~flush;
  assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: an instruction-level pipeline model predicts every cycle's outputs.
module tb_fwd_hazard_unit;

  localparam int AW   = 5;
  localparam int CNTW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            id_valid, id_use_rs, id_use_rt, id_we, id_load, ext_stall, flush;
  logic [AW-1:0]   id_rs, id_rt, id_wreg;
  logic [1:0]      fwd_a, fwd_b;
  logic            stall_id;
  logic [CNTW-1:0] bubble_cnt;

  fwd_hazard_unit #(.AW(AW), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_wreg(id_wreg), .id_we(id_we), .id_load(id_load),
    .ext_stall(ext_stall), .flush(flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_id(stall_id), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit valid;
    int rs;
    int rt;
    bit use_rs;
    bit use_rt;
    int wreg;
    bit we;
    bit load;
  } ins_t;

  typedef struct {
    int fa;
    int fb;
    int st;
    int cnt;
  } exp_t;

  ins_t bub = '{default: 0};
  ins_t pipe [3];   // 0 = EX, 1 = MEM, 2 = WB
  int   mcnt;
  exp_t sb [$];
  int   checks   = 0;
  int   failures = 0;

  function automatic ins_t alu(int d, int a, int b);
    ins_t i = '{default: 0};
    i.valid = 1; i.rs = a; i.rt = b; i.use_rs = 1; i.use_rt = 1;
    i.wreg = d; i.we = 1; i.load = 0;
    return i;
  endfunction

  function automatic ins_t lw(int d, int base);
    ins_t i = '{default: 0};
    i.valid = 1; i.rs = base; i.use_rs = 1; i.wreg = d; i.we = 1; i.load = 1;
    return i;
  endfunction

  // A consumer in ID needs a loaded value that the instruction in EX has not yet fetched.
  function automatic bit model_lu(ins_t id);
    ins_t ex = pipe[0];
    if (!id.valid || !ex.valid || !ex.load || !ex.we || ex.wreg == 0) return 0;
    return (id.use_rs && id.rs == ex.wreg) || (id.use_rt && id.rt == ex.wreg);
  endfunction

  // Walk older instructions youngest first; the first one holding a ready result supplies it.
  function automatic int model_fwd(int src, bit used);
    if (!pipe[0].valid || !used || src == 0) return 0;
    for (int k = 1; k <= 2; k++) begin
      if (pipe[k].valid && pipe[k].we && pipe[k].wreg == src && !(k == 1 && pipe[k].load))
        return k;
    end
    return 0;
  endfunction

  task automatic step(input ins_t ins, input bit ext, input bit fl, output bit held);
    exp_t e;
    bit   lu;
    id_valid  = ins.valid;
    id_rs     = AW'(ins.rs);
    id_rt     = AW'(ins.rt);
    id_use_rs = ins.use_rs;
    id_use_rt = ins.use_rt;
    id_wreg   = AW'(ins.wreg);
    id_we     = ins.we;
    id_load   = ins.load;
    ext_stall = ext;
    flush     = fl;
    lu    = model_lu(ins);
    e.fa  = model_fwd(pipe[0].rs, pipe[0].use_rs);
    e.fb  = model_fwd(pipe[0].rt, pipe[0].use_rt);
    e.st  = (lu && !fl) ? 1 : 0;
    e.cnt = mcnt;
    sb.push_back(e);
    if (fl) begin
      pipe[2] = pipe[1];
      pipe[1] = bub;
      pipe[0] = bub;
    end else if (!ext) begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = (lu || !ins.valid) ? bub : ins;
      if (lu) mcnt = (mcnt + 1) % (1 << CNTW);
    end
    held = !fl && (ext || lu);
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input ins_t ins);
    bit held;
    int n = 0;
    do begin
      step(ins, 1'b0, 1'b0, held);
      n++;
    end while (held && n < 4);
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) issue(bub);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare mid-cycle against the oldest prediction.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("fwd_a", int'(fwd_a), e.fa);
      chk("fwd_b", int'(fwd_b), e.fb);
      chk("stall_id", int'(stall_id), e.st);
      chk("bubble_cnt", int'(bubble_cnt), e.cnt);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit   held;
    ins_t cur;
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      id_valid  = 1'($urandom);  id_rs   = AW'($urandom); id_rt   = AW'($urandom);
      id_use_rs = 1'($urandom);  id_use_rt = 1'($urandom); id_wreg = AW'($urandom);
      id_we     = 1'($urandom);  id_load = 1'($urandom);
      ext_stall = 1'($urandom);  flush   = 1'($urandom);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) pipe[k] = bub;
    mcnt = 0;

    // Back-to-back and one-apart ALU forwarding.
    issue(alu(3, 1, 2)); issue(alu(4, 3, 3)); nops(3);
    issue(alu(3, 1, 2)); issue(alu(9, 8, 8)); issue(alu(4, 3, 3)); nops(3);
    // Load-use with $0 as the second operand.
    issue(lw(5, 1)); issue(alu(6, 5, 0)); nops(3);
    // MEM beats WB, then $0 producers.
    issue(alu(7, 1, 2)); issue(alu(7, 2, 3)); issue(alu(8, 7, 1)); nops(3);
    issue(alu(0, 1, 2)); issue(alu(8, 0, 0)); issue(lw(0, 1)); issue(alu(9, 0, 0)); nops(3);
    // Freeze during a load-use, then release.
    issue(lw(5, 1));
    for (int i = 0; i < 3; i++) step(alu(6, 5, 5), 1'b1, 1'b0, held);
    issue(alu(6, 5, 5)); nops(3);
    // Flush with a producer in EX.
    issue(alu(10, 1, 2));
    step(alu(11, 10, 10), 1'b0, 1'b1, held);
    issue(alu(12, 10, 10)); nops(3);
    // More load-use bubbles to walk the counter through its wrap.
    for (int i = 0; i < 5; i++) begin
      issue(lw(2, 1)); issue(alu(3, 2, 4));
    end
    nops(3);

    // Randomized traffic over a small register set to provoke hazards.
    held = 1'b0;
    cur  = bub;
    for (int c = 0; c < 600; c++) begin
      bit ext, fl;
      if (!held) begin
        cur.valid  = ($urandom_range(99) < 85);
        cur.rs     = $urandom_range(7);
        cur.rt     = $urandom_range(7);
        cur.use_rs = 1'($urandom);
        cur.use_rt = 1'($urandom);
        cur.wreg   = $urandom_range(7);
        cur.we     = ($urandom_range(99) < 80);
        cur.load   = ($urandom_range(99) < 30);
      end
      ext = ($urandom_range(99) < 10);
      fl  = ($urandom_range(99) < 5);
      step(cur, ext, fl, held);
    end
    nops(2);

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d predictions left unchecked, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Forwarding and load-use hazard controller for the 5-stage MIPS core. It keeps a shadow copy of the destination-register bookkeeping for the EX, MEM and WB stages, advancing in lockstep with the datapath pipeline. It generates the 2-bit operand-select codes for the EX-stage three-input operand muxes (0 = register file, 1 = MEM-stage result, 2 = WB-stage result) and the one-bubble load-use stall for the ID stage. It also counts the bubbles it inserts.

## Interface
Parameters:
- AW, 5, register-index width.
- CNTW, 32, width of the stall-bubble counter.

Ports:
- clk, in, 1, core clock. All state changes on the rising edge.
- rst, in, 1, synchronous active-high reset.
- id_valid, in, 1, ID holds a real instruction.
- id_rs, in, AW, ID source index A.
- id_rt, in, AW, ID source index B.
- id_use_rs, in, 1, ID instruction reads rs.
- id_use_rt, in, 1, ID instruction reads rt.
- id_wreg, in, AW, ID destination index.
- id_we, in, 1, ID instruction writes the register file.
- id_load, in, 1, ID instruction is a load.
- ext_stall, in, 1, whole-pipeline freeze (memory wait).
- flush, in, 1, squash the instructions in ID and EX (exception or eret).
- fwd_a, out, 2, operand A select for the EX instruction.
- fwd_b, out, 2, operand B select for the EX instruction.
- stall_id, out, 1, hold PC and IF/ID this cycle, and insert a bubble into EX.
- bubble_cnt, out, CNTW, number of load-use bubbles inserted.

## Operation
- **State.** Three entries: EX, MEM and WB. Each entry holds {valid, wreg, we, load}. The EX entry also holds {rs, rt, use_rs, use_rt}. A bubble is an entry with all fields zero.
- **Load-use hazard.** lu = id_valid & EX.valid & EX.load & EX.we & (EX.wreg != 0) & ((id_use_rs & id_rs == EX.wreg) | (id_use_rt & id_rt == EX.wreg)).
- **stall_id** = lu & !flush. It is combinational from the inputs and the EX entry.
- **Pipeline advance.** Evaluated in priority order:
  - **flush = 1** (overrides ext_stall): EX <= bubble, MEM <= bubble, WB <= old MEM.
  - **else ext_stall = 1:** all entries hold.
  - **else:** WB <= MEM, MEM <= EX. EX <= bubble if lu or !id_valid; otherwise EX <= the ID fields.
- **Forward select for operand A.** The same rules apply to operand B with rt/use_rt.
  - Result is 0 if !EX.valid, !EX.use_rs, or EX.rs == 0.
  - Otherwise result is 1 if MEM.valid & MEM.we & !MEM.load & MEM.wreg == EX.rs.
  - Otherwise result is 2 if WB.valid & WB.we & WB.wreg == EX.rs.
  - Otherwise result is 0.
  - MEM has priority over WB, so the youngest producer wins.
- **Encoding 3** is never driven.
- **Load in MEM.** A load in MEM never produces code 1. The lu stall guarantees that the consumer sees the load in WB, which produces code 2.
- **bubble_cnt** increments by 1 on each edge where lu=1, flush=0 and ext_stall=0. It wraps modulo 2^CNTW.
- **Outputs during ext_stall.** fwd_a/fwd_b are functions of registered state only, so they are stable for the whole freeze.

## Timing
- **Reset.** All entries become bubbles and bubble_cnt=0. Hence fwd_a=fwd_b=0 and stall_id=0 in the first cycle after reset. rst has priority over flush and ext_stall.
- **Latency.**
  - fwd_a/fwd_b are valid in the same cycle the consumer occupies EX, with no extra delay.
  - stall_id is valid in the same cycle as the ID inputs.
- **Load-use penalty.** Exactly one bubble. In the cycle after a stall, the load is in MEM and the consumer is still in ID; lu is then 0, and the consumer enters EX one cycle later with fwd=2.
- **Simultaneous events.**
  - lu together with ext_stall: stall_id stays high, no bubble is inserted or counted, and the entries hold.
  - lu together with flush: stall_id=0 and no count.
- **Register 0.** Writes to $0 never cause forwarding or a stall.

## Test plan
- **Reset.** Assert rst for 2 cycles with random inputs, then release → fwd_a=fwd_b=0, stall_id=0, bubble_cnt=0.
- **Back-to-back ALU forwarding.** Issue `add $3,$1,$2`, then `sub $4,$3,$3` (uses both operands) → when sub is in EX: fwd_a=1, fwd_b=1. Repeat with one unrelated instruction between them → fwd_a=fwd_b=2.
- **Load-use.** Issue `lw $5,0($1)`, then `add $6,$5,$0` → stall_id=1 for exactly 1 cycle, bubble_cnt=1. When add reaches EX: fwd_a=2, fwd_b=0.
- **Priority and $0.** The EX instruction reads $7, MEM writes $7 (ALU), and WB writes $7 → fwd_a=1. Then repeat with writer and reader both using $0 → fwd=0 and stall_id=0.
- **Freeze and flush.**
  - Hold ext_stall=1 for 3 cycles during a load-use case → stall_id stays 1, bubble_cnt is unchanged, and fwd is stable.
  - Then pulse flush with a producer in EX → next cycle EX and MEM are bubbles, fwd=0 for the following instruction.
- **Counter wrap.** Use CNTW=2 and 5 load-use bubbles → bubble_cnt sequence 1,2,3,0,1.
